// File: rtl/agc_pkg.sv
// Shared constants, derived widths and saturation limits for the AGC gain stage.
package agc_pkg;

   localparam int unsigned F_GAIN_DEF = 14;
   localparam int unsigned GAIN_ONE   = 1 << F_GAIN_DEF;
   localparam int unsigned ROUND_HALF = 1 << (F_GAIN_DEF - 1);

   function automatic int unsigned loop_prod_w(input int unsigned w_alpha, input int unsigned w_mag);
      return w_alpha + w_mag + 2;
   endfunction

   // One bit beyond the wider addend, so the gain sum can never wrap.
   function automatic int unsigned loop_sum_w(input int unsigned w_prod, input int unsigned w_gain);
      return ((w_prod > w_gain + 1) ? w_prod : w_gain + 1) + 1;
   endfunction

   function automatic int unsigned data_prod_w(input int unsigned w_in, input int unsigned w_gain);
      return w_in + w_gain + 1;
   endfunction

   localparam int unsigned W_LOOP_PROD = loop_prod_w(16, 16);
   localparam int unsigned W_LOOP_SUM  = loop_sum_w(W_LOOP_PROD, 18);
   localparam int unsigned W_DATA_PROD = data_prod_w(16, 18);

   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/agc_round_sat.sv
// Round-half-up, shift by F and saturate one channel product to W_OUT bits.
module agc_round_sat
   import agc_pkg::*;
#(
   parameter int unsigned W_P   = W_DATA_PROD,
   parameter int unsigned W_OUT = 16,
   parameter int unsigned F     = F_GAIN_DEF
) (
   input  logic signed [W_P-1:0]   p_i,
   output logic signed [W_OUT-1:0] data_o,
   output logic                    sat_o
);

   localparam int unsigned W_R = W_P + 1;
   localparam logic signed [W_R-1:0] ROUND = W_R'(longint'(1) <<< (F - 1));
   localparam logic signed [W_R-1:0] SMAX  = W_R'(sat_max(W_OUT));
   localparam logic signed [W_R-1:0] SMIN  = W_R'(sat_min(W_OUT));

   logic signed [W_R-1:0] sum;
   logic signed [W_R-1:0] r;

   always_comb begin
      sum    = $signed({p_i[W_P-1], p_i}) + ROUND;
      r      = sum >>> F;
      data_o = r[W_OUT-1:0];
      sat_o  = 1'b0;
      if (r > SMAX) begin
         data_o = SMAX[W_OUT-1:0];
         sat_o  = 1'b1;
      end else if (r < SMIN) begin
         data_o = SMIN[W_OUT-1:0];
         sat_o  = 1'b1;
      end
   end

endmodule

// File: rtl/agc_gain_stage.sv
// AGC gain stage: level-error integrator into a clamped gain register, and a
// 3-stage I/Q multiply / round / saturate data path using that gain.
module agc_gain_stage
   import agc_pkg::*;
#(
   parameter int unsigned W_IN      = 16,
   parameter int unsigned W_OUT     = 16,
   parameter int unsigned W_MAG     = 16,
   parameter int unsigned W_ALPHA   = 16,
   parameter int unsigned F_ALPHA   = 14,
   parameter int unsigned W_GAIN    = 18,
   parameter int unsigned F_GAIN    = F_GAIN_DEF,
   parameter int unsigned GAIN_INIT = GAIN_ONE,
   parameter int unsigned GAIN_MIN  = 1,
   parameter int unsigned GAIN_MAX  = 262143
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [W_ALPHA-1:0]      i_alpha,
   input  logic [W_MAG-1:0]        i_reference,
   input  logic                    i_freeze,
   input  logic                    i_gain_load,
   input  logic [W_GAIN-1:0]       i_gain_value,
   input  logic [W_MAG-1:0]        s_level,
   input  logic                    s_level_valid,
   input  logic signed [W_IN-1:0]  s_chans_dataI,
   input  logic signed [W_IN-1:0]  s_chans_dataQ,
   input  logic                    s_chans_valid,
   output logic signed [W_OUT-1:0] m_chans_dataI,
   output logic signed [W_OUT-1:0] m_chans_dataQ,
   output logic                    m_chans_valid,
   output logic                    m_sat,
   output logic [W_GAIN-1:0]       o_gain
);

   localparam int unsigned W_PR = loop_prod_w(W_ALPHA, W_MAG);
   localparam int unsigned W_S  = loop_sum_w(W_PR, W_GAIN);
   localparam int unsigned W_P  = data_prod_w(W_IN, W_GAIN);

   localparam logic signed [W_S-1:0] MIN_S = W_S'(GAIN_MIN);
   localparam logic signed [W_S-1:0] MAX_S = W_S'(GAIN_MAX);
   localparam logic [W_GAIN-1:0]     MIN_G = W_GAIN'(GAIN_MIN);
   localparam logic [W_GAIN-1:0]     MAX_G = W_GAIN'(GAIN_MAX);

   logic signed [W_MAG:0]    err;
   logic signed [W_PR-1:0]   prod_d, prod_q, shifted;
   logic signed [W_S-1:0]    sum;
   logic                     g1_valid_d, g1_valid_q;
   logic [W_GAIN-1:0]        gain_d, gain_q;

   logic                     d1_valid_q, d2_valid_q, m_valid_q, m_sat_q;
   logic signed [W_IN-1:0]   d1_i_q, d1_q_q;
   logic [W_GAIN-1:0]        d1_g_q;
   logic signed [W_P-1:0]    pi_d, pq_d, d2_pi_q, d2_pq_q;
   logic signed [W_OUT-1:0]  ri, rq, m_i_q, m_q_q;
   logic                     sati, satq;

   always_comb begin
      err     = $signed({1'b0, i_reference}) - $signed({1'b0, s_level});
      prod_d  = $signed({{(W_PR - W_ALPHA){1'b0}}, i_alpha})
              * $signed({{(W_PR - W_MAG - 1){err[W_MAG]}}, err});
      shifted = prod_q >>> F_ALPHA;
      sum     = $signed({{(W_S - W_PR){shifted[W_PR-1]}}, shifted})
              + $signed({{(W_S - W_GAIN){1'b0}}, gain_q});

      gain_d     = gain_q;
      g1_valid_d = s_level_valid && !i_freeze;
      // A load both wins over the commit and flushes any update still in G1.
      if (i_gain_load) begin
         g1_valid_d = 1'b0;
         if (i_gain_value < MIN_G)      gain_d = MIN_G;
         else if (i_gain_value > MAX_G) gain_d = MAX_G;
         else                           gain_d = i_gain_value;
      end else if (g1_valid_q) begin
         if (sum < MIN_S)      gain_d = MIN_G;
         else if (sum > MAX_S) gain_d = MAX_G;
         else                  gain_d = sum[W_GAIN-1:0];
      end
   end

   always_comb begin
      pi_d = $signed({{(W_P - W_IN){d1_i_q[W_IN-1]}}, d1_i_q})
           * $signed({{(W_P - W_GAIN){1'b0}}, d1_g_q});
      pq_d = $signed({{(W_P - W_IN){d1_q_q[W_IN-1]}}, d1_q_q})
           * $signed({{(W_P - W_GAIN){1'b0}}, d1_g_q});
   end

   agc_round_sat #(.W_P(W_P), .W_OUT(W_OUT), .F(F_GAIN)) u_rs_i (
      .p_i(d2_pi_q), .data_o(ri), .sat_o(sati)
   );

   agc_round_sat #(.W_P(W_P), .W_OUT(W_OUT), .F(F_GAIN)) u_rs_q (
      .p_i(d2_pq_q), .data_o(rq), .sat_o(satq)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         gain_q     <= W_GAIN'(GAIN_INIT);
         g1_valid_q <= 1'b0;
         prod_q     <= '0;
         d1_valid_q <= 1'b0;
         d1_i_q     <= '0;
         d1_q_q     <= '0;
         d1_g_q     <= '0;
         d2_valid_q <= 1'b0;
         d2_pi_q    <= '0;
         d2_pq_q    <= '0;
         m_valid_q  <= 1'b0;
         m_i_q      <= '0;
         m_q_q      <= '0;
         m_sat_q    <= 1'b0;
      end else begin
         gain_q     <= gain_d;
         g1_valid_q <= g1_valid_d;
         if (g1_valid_d) prod_q <= prod_d;
         // D1 snapshots the gain as it stood before this cycle's commit.
         d1_valid_q <= s_chans_valid;
         if (s_chans_valid) begin
            d1_i_q <= s_chans_dataI;
            d1_q_q <= s_chans_dataQ;
            d1_g_q <= gain_q;
         end
         d2_valid_q <= d1_valid_q;
         if (d1_valid_q) begin
            d2_pi_q <= pi_d;
            d2_pq_q <= pq_d;
         end
         m_valid_q <= d2_valid_q;
         m_sat_q   <= d2_valid_q && (sati || satq);
         if (d2_valid_q) begin
            m_i_q <= ri;
            m_q_q <= rq;
         end
      end
   end

   assign m_chans_dataI = m_i_q;
   assign m_chans_dataQ = m_q_q;
   assign m_chans_valid = m_valid_q;
   assign m_sat         = m_sat_q;
   assign o_gain        = gain_q;

endmodule
